// File: rtl/alu_cmd_sequencer.sv
// Replays a host-loaded program of byte-ALU commands at one per cycle and
// captures flagged ALU results into a result buffer for host readback.
module alu_cmd_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         ALU_LATENCY = 1,
  parameter logic [3:0] NOP_OPCODE  = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic [6:0]               load_ctrl,
  input  logic [7:0]               load_data,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               alu_opcode,
  output logic                     alu_accum_source,
  output logic                     alu_value_source,
  output logic [7:0]               alu_data,
  input  logic [7:0]               alu_result,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic [$clog2(DEPTH):0]   res_count,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] prog_count_q, prog_count_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [1:0]    drain_q, drain_d;
  logic [3:0]    opcode_q, opcode_d;
  logic          accum_q, accum_d;
  logic          value_q, value_d;
  logic [7:0]    data_q, data_d;
  logic          cap_q [ALU_LATENCY+1];
  logic          cap_d;
  logic [7:0]    rd_data_q;

  // Entry layout: [14]=capture, [13]=accum_source, [12]=value_source, [11:8]=opcode, [7:0]=operand
  logic [14:0]   prog_mem [DEPTH];
  logic [7:0]    res_mem  [DEPTH];

  logic          load_fire;
  logic          capture_fire;
  logic          issue;
  logic [14:0]   issue_entry;

  assign load_ready = (state_q == IDLE) && (prog_count_q < CW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    prog_count_d = prog_count_q;
    res_count_d  = res_count_q;
    pc_d         = pc_q;
    drain_d      = drain_q;
    load_fire    = 1'b0;
    issue        = 1'b0;
    issue_entry  = '0;
    capture_fire = cap_q[ALU_LATENCY] && (res_count_q < CW'(DEPTH));

    if (capture_fire) res_count_d = res_count_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (clear) begin
          prog_count_d = '0;
          res_count_d  = '0;
        end else begin
          load_fire = load_valid && load_ready;
          if (load_fire) prog_count_d = prog_count_q + CW'(1);
          if (start) begin
            res_count_d = '0;
            if (prog_count_d != '0) begin
              // Entry 0 may be the one being written this same cycle
              issue       = 1'b1;
              issue_entry = (prog_count_q == '0) ? {load_ctrl, load_data} : prog_mem[0];
              pc_d        = CW'(1);
              state_d     = RUN;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      RUN: begin
        if (pc_q == prog_count_q) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          issue       = 1'b1;
          issue_entry = prog_mem[pc_q[AW-1:0]];
          pc_d        = pc_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'(ALU_LATENCY - 1)) state_d = DONE;
        else                                drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    opcode_d = issue ? issue_entry[11:8] : NOP_OPCODE;
    accum_d  = issue && issue_entry[13];
    value_d  = issue && issue_entry[12];
    data_d   = issue ? issue_entry[7:0] : 8'h00;
    cap_d    = issue && issue_entry[14];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prog_count_q <= '0;
      res_count_q  <= '0;
      pc_q         <= '0;
      drain_q      <= '0;
      opcode_q     <= NOP_OPCODE;
      accum_q      <= 1'b0;
      value_q      <= 1'b0;
      data_q       <= 8'h00;
      cap_q[0]     <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      prog_count_q <= prog_count_d;
      res_count_q  <= res_count_d;
      pc_q         <= pc_d;
      drain_q      <= drain_d;
      opcode_q     <= opcode_d;
      accum_q      <= accum_d;
      value_q      <= value_d;
      data_q       <= data_d;
      cap_q[0]     <= cap_d;
      rd_data_q    <= res_mem[rd_addr];
    end
  end

  // Stage N of the capture pipe lines up with the result of the command issued N cycles earlier
  genvar gi;
  generate
    for (gi = 1; gi <= ALU_LATENCY; gi++) begin : g_cap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap_q[gi] <= 1'b0;
        else        cap_q[gi] <= cap_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (load_fire)    prog_mem[prog_count_q[AW-1:0]] <= {load_ctrl, load_data};
    if (capture_fire) res_mem[res_count_q[AW-1:0]]   <= alu_result;
  end

  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign alu_opcode       = opcode_q;
  assign alu_accum_source = accum_q;
  assign alu_value_source = value_q;
  assign alu_data         = data_q;
  assign prog_count       = prog_count_q;
  assign res_count        = res_count_q;
  assign rd_data          = rd_data_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: two sequencers (ALU latency 1 and 3) share host stimulus,
// each driving its own XOR ALU stub.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          load_valid;
  logic [6:0]    load_ctrl;
  logic [7:0]    load_data;
  logic          clear;
  logic          start;
  logic [AW-1:0] rd_addr;

  logic          load_ready1, busy1, done1, acc1, val1;
  logic [3:0]    op1;
  logic [7:0]    data1, res1, rd_data1;
  logic [CW-1:0] prog_count1, res_count1;

  logic          load_ready3, busy3, done3, acc3, val3;
  logic [3:0]    op3;
  logic [7:0]    data3, res3, rd_data3, s3a, s3b;
  logic [CW-1:0] prog_count3, res_count3;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(1), .NOP_OPCODE(4'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ctrl(load_ctrl),
    .load_data(load_data), .load_ready(load_ready1), .clear(clear), .start(start),
    .busy(busy1), .done(done1), .alu_opcode(op1), .alu_accum_source(acc1),
    .alu_value_source(val1), .alu_data(data1), .alu_result(res1),
    .prog_count(prog_count1), .res_count(res_count1), .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(3), .NOP_OPCODE(4'h0)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ctrl(load_ctrl),
    .load_data(load_data), .load_ready(load_ready3), .clear(clear), .start(start),
    .busy(busy3), .done(done3), .alu_opcode(op3), .alu_accum_source(acc3),
    .alu_value_source(val3), .alu_data(data3), .alu_result(res3),
    .prog_count(prog_count3), .res_count(res_count3), .rd_addr(rd_addr), .rd_data(rd_data3)
  );

  always_ff @(posedge clk) begin
    res1 <= data1 ^ {4'h0, op1};
    s3a  <= data3 ^ {4'h0, op3};
    s3b  <= s3a;
    res3 <= s3b;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic cap, input logic [3:0] op, input logic [7:0] d);
    load_valid = 1'b1;
    load_ctrl  = {cap, 2'b00, op};
    load_data  = d;
    tick();
    load_valid = 1'b0;
    $display("load cap=%0d op=%0h data=%02h -> prog_count=%0d", cap, op, d, prog_count1);
  endtask

  // Three-entry program: ops 1,2,3 then NOP; done at +5 (lat 1) and +7 (lat 3)
  task automatic run_three(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("%s op1 c%0d", tag, k), op1, (k <= 3) ? k : 0);
      check($sformatf("%s op3 c%0d", tag, k), op3, (k <= 3) ? k : 0);
      check($sformatf("%s done1 c%0d", tag, k), done1, k == 5);
      check($sformatf("%s done3 c%0d", tag, k), done3, k == 7);
      check($sformatf("%s busy1 c%0d", tag, k), busy1, k <= 4);
      check($sformatf("%s busy3 c%0d", tag, k), busy3, k <= 6);
      if (k == 1) check($sformatf("%s data1 c1", tag), data1, 8'h10);
      if (k < 7) tick();
    end
    check({tag, " res_count1"}, res_count1, 2);
    check({tag, " res_count3"}, res_count3, 2);
    rd_addr = 4'd0;
    tick();
    check({tag, " rd0 lat1"}, rd_data1, 8'h11);
    check({tag, " rd0 lat3"}, rd_data3, 8'h11);
    rd_addr = 4'd1;
    tick();
    check({tag, " rd1 lat1"}, rd_data1, 8'h33);
    check({tag, " rd1 lat3"}, rd_data3, 8'h33);
    $display("%s run: res_count=%0d results %02h %02h", tag, res_count1, 8'h11, rd_data1);
  endtask

  initial begin
    int  d1;
    int  d3;
    logic done_seen;

    rst_n = 1'b0; load_valid = 1'b0; load_ctrl = '0; load_data = '0;
    clear = 1'b0; start = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst prog_count", prog_count1, 0);
    check("rst res_count", res_count1, 0);
    check("rst busy", busy1, 0);
    check("rst done", done1, 0);
    check("rst load_ready", load_ready1, 1);
    check("rst rd_data", rd_data1, 0);
    check("rst opcode", op1, 4'h0);
    check("rst alu_data", data1, 0);
    rst_n = 1'b1;
    tick();

    load_entry(1'b1, 4'h1, 8'h10);
    load_entry(1'b0, 4'h2, 8'h20);
    load_entry(1'b1, 4'h3, 8'h30);
    check("prog_count after 3", prog_count1, 3);
    run_three("first");
    run_three("rerun");

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear prog_count", prog_count1, 0);
    check("clear res_count", res_count1, 0);
    $display("clear: prog_count=%0d res_count=%0d", prog_count1, res_count1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty done", done1, 1);
    check("empty busy", busy1, 0);
    check("empty opcode", op1, 4'h0);
    check("empty res_count", res_count1, 0);
    tick();
    check("empty done low", done1, 0);
    check("empty busy low", busy1, 0);
    $display("empty start: done pulsed, res_count=%0d", res_count1);

    load_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check($sformatf("burst load_ready i%0d", i), load_ready1, i < DEPTH);
      load_ctrl = {(i % 3 == 0), 2'b00, 4'(i)};
      load_data = 8'(i * 16 + 5);
      tick();
    end
    load_valid = 1'b0;
    check("burst prog_count", prog_count1, DEPTH);
    check("burst prog_count lat3", prog_count3, DEPTH);
    check("burst load_ready", load_ready1, 0);
    $display("burst load: prog_count=%0d", prog_count1);

    start = 1'b1;
    tick();
    start = 1'b0;
    d1 = -1;
    d3 = -1;
    for (int c = 1; c <= 25; c++) begin
      if (done1 && d1 < 0) d1 = c;
      if (done3 && d3 < 0) d3 = c;
      tick();
    end
    check("full done1 cycle", d1, 18);
    check("full done3 cycle", d3, 20);
    check("full res_count1", res_count1, 6);
    check("full res_count3", res_count3, 6);
    rd_addr = 4'd1;
    tick();
    check("full rd1", rd_data1, 8'h36);
    rd_addr = 4'd5;
    tick();
    check("full rd5", rd_data1, 8'hFA);
    check("full rd5 lat3", rd_data3, 8'hFA);
    $display("full run: done at +%0d/+%0d res_count=%0d", d1, d3, res_count1);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrun op before reset", op1, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy1", busy1, 0);
    check("async reset busy3", busy3, 0);
    check("async reset op1", op1, 4'h0);
    check("async reset op3", op3, 4'h0);
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      done_seen = done_seen | done1 | done3;
      tick();
    end
    check("after reset no done", done_seen, 0);
    check("after reset prog_count", prog_count1, 0);
    check("after reset busy", busy1, 0);
    $display("mid-run reset: prog_count=%0d busy=%0d", prog_count1, busy1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
